// File: rtl/result_drain_if.sv
// Write-side and output-stream handshake bundle for result_drain.
// slave is the drain block's view; master is the datapath/consumer view.
interface result_drain_if #(
    parameter int WIDTH = 8
);
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             wr_ready;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport slave (
        input  wr_en, wr_data, out_ready,
        output wr_ready, out_valid, out_data
    );

    modport master (
        output wr_en, wr_data, out_ready,
        input  wr_ready, out_valid, out_data
    );
endinterface

// File: rtl/result_drain.sv
// Collects DEPTH result bytes, replays them in write order on a valid/ready stream, then pulses done.
// Optional per-entry even parity when RESULT_DRAIN_PARITY_EN is defined.
module result_drain #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic            clk,
    input  logic            reset,
    result_drain_if.slave   bus,
    output logic [AW:0]     o_count,
    output logic            o_done,
    output logic            o_overrun
`ifdef RESULT_DRAIN_PARITY_EN
    ,
    output logic            o_out_parity,
    output logic            o_parity_err
`endif
);

    typedef enum logic [1:0] {
        S_FILL,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_t           r_state;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             r_out_valid;
    logic             r_wr_ready;
    logic             r_done;
    logic             r_overrun;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic             w_wr_fire;
    logic             w_rd_fire;
    logic [WIDTH-1:0] w_rd_data;

    // wr_ready is high exactly in FILL, so it doubles as the state decode for writes.
    assign w_wr_fire = r_wr_ready & bus.wr_en;
    assign w_rd_fire = r_out_valid & bus.out_ready;
    assign w_rd_data = r_mem[r_rd_ptr];

    // NOTE: the buffer has no reset; a stale entry is never visible because out_valid gates it.
    always_ff @(posedge clk) begin
        if (!reset && w_wr_fire)
            r_mem[r_wr_ptr] <= bus.wr_data;
    end

`ifdef RESULT_DRAIN_PARITY_EN
    logic r_par_mem [DEPTH];
    logic r_parity_err;

    always_ff @(posedge clk) begin
        if (!reset && w_wr_fire)
            r_par_mem[r_wr_ptr] <= ^bus.wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_parity_err <= 1'b0;
        else if (w_rd_fire && (r_par_mem[r_rd_ptr] != ^w_rd_data))
            r_parity_err <= 1'b1;
    end

    assign o_out_parity = r_out_valid & (^w_rd_data);
    assign o_parity_err = r_parity_err;
`endif

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_FILL;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_wr_ready  <= 1'b1;
            r_done      <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_FILL: begin
                    if (bus.wr_en) begin
                        r_wr_ptr <= r_wr_ptr + 1'b1;
                        r_count  <= r_count + 1'b1;
                        if (r_wr_ptr == LAST) begin
                            r_state     <= S_DRAIN;
                            r_rd_ptr    <= '0;
                            r_wr_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (bus.wr_en)
                        r_overrun <= 1'b1;
                    if (bus.out_ready) begin
                        r_rd_ptr <= r_rd_ptr + 1'b1;
                        r_count  <= r_count - 1'b1;
                        if (r_rd_ptr == LAST) begin
                            r_state     <= S_DONE;
                            r_out_valid <= 1'b0;
                            r_done      <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (bus.wr_en)
                        r_overrun <= 1'b1;
                    r_state    <= S_FILL;
                    r_wr_ready <= 1'b1;
                end
                default: begin
                    r_state     <= S_FILL;
                    r_wr_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.wr_ready  = r_wr_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_valid ? w_rd_data : '0;
    assign o_count       = r_count;
    assign o_done        = r_done;
    assign o_overrun     = r_overrun;

endmodule

// File: tb/tb_result_drain.sv
// Self-checking bench for result_drain: scoreboard queue of written bytes, popped on each handshake.
// Parity scenario is compiled in only when RESULT_DRAIN_PARITY_EN is defined.
module tb_result_drain;

    logic       clk;
    logic       reset;
    logic [2:0] o_count;
    logic       o_done;
    logic       o_overrun;
`ifdef RESULT_DRAIN_PARITY_EN
    logic       o_out_parity;
    logic       o_parity_err;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_q [$];

    result_drain_if #(.WIDTH(8)) bus ();

    result_drain #(.WIDTH(8), .DEPTH(4), .AW(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .o_count   (o_count),
        .o_done    (o_done),
        .o_overrun (o_overrun)
`ifdef RESULT_DRAIN_PARITY_EN
        ,
        .o_out_parity (o_out_parity),
        .o_parity_err (o_parity_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs are driven and outputs sampled on the falling edge.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.wr_en = 1'b0;
        bus.out_ready = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;
        exp_q.delete();
    endtask

    // Four consecutive writes; must start on a cycle where wr_ready is high.
    task automatic fill(input logic [7:0] d0, input logic [7:0] d1,
                        input logic [7:0] d2, input logic [7:0] d3);
        logic [7:0] d [4];
        d = '{d0, d1, d2, d3};
        for (int i = 0; i < 4; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = d[i];
            exp_q.push_back(d[i]);
            cyc();
            n_cmp++;
            if (o_count !== 3'(i + 1)) begin
                n_bad++;
                $display("FAIL fill_count[%0d]: got %0d expected %0d", i, o_count, i + 1);
            end
        end
        bus.wr_en = 1'b0;
        n_cmp++;
        if (bus.out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL fill_valid: out_valid got %b expected 1 after 4th write", bus.out_valid);
        end
    endtask

    // Drains the scoreboard with out_ready high, then checks done and wr_ready return.
    task automatic drain_q(input string tag);
        int guard = 0;
        logic [7:0] e;
        bus.out_ready = 1'b1;
        while (exp_q.size() > 0 && guard < 20) begin
            if (bus.out_valid === 1'b1) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (bus.out_data !== e || o_count !== 3'(exp_q.size() + 1)) begin
                    n_bad++;
                    $display("FAIL %s_data: got %h count %0d expected %h count %0d",
                             tag, bus.out_data, o_count, e, exp_q.size() + 1);
                end
            end
            cyc();
            guard++;
        end
        bus.out_ready = 1'b0;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s_timeout: %0d entries left, expected 0", tag, exp_q.size());
            exp_q.delete();
        end
        n_cmp++;
        if (o_done !== 1'b1 || bus.out_valid !== 1'b0 || o_count !== 3'd0 || bus.wr_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_done: done %b valid %b count %0d wr_ready %b expected 1 0 0 0",
                     tag, o_done, bus.out_valid, o_count, bus.wr_ready);
        end
        cyc();
        n_cmp++;
        if (o_done !== 1'b0 || bus.wr_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_rearm: done %b wr_ready %b expected 0 1", tag, o_done, bus.wr_ready);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (o_count !== 3'd0 || bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 ||
            o_done !== 1'b0 || o_overrun !== 1'b0 || bus.wr_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset: count %0d valid %b data %h done %b ovr %b wr_ready %b expected 0 0 00 0 0 1",
                     o_count, bus.out_valid, bus.out_data, o_done, o_overrun, bus.wr_ready);
        end
    endtask

    task automatic test_basic();
        bus.out_ready = 1'b1;
        fill(8'h11, 8'h22, 8'h33, 8'h44);
        drain_q("basic");
    endtask

    task automatic test_stall();
        logic pat [4];
        pat = '{1'b1, 1'b0, 1'b1, 1'b0};
        bus.out_ready = 1'b0;
        fill(8'hA0, 8'hA1, 8'hA2, 8'hA3);
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA0 || o_count !== 3'd4) begin
                n_bad++;
                $display("FAIL stall_hold[%0d]: valid %b data %h count %0d expected 1 a0 4",
                         i, bus.out_valid, bus.out_data, o_count);
            end
            cyc();
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (bus.out_data !== exp_q[0]) begin
                n_bad++;
                $display("FAIL stall_toggle[%0d]: data %h expected %h", i, bus.out_data, exp_q[0]);
            end
            bus.out_ready = pat[i];
            cyc();
            if (pat[i])
                void'(exp_q.pop_front());
        end
        n_cmp++;
        if (bus.out_data !== 8'hA2 || o_count !== 3'd2) begin
            n_bad++;
            $display("FAIL stall_after: data %h count %0d expected a2 2", bus.out_data, o_count);
        end
        drain_q("stall");
    endtask

    task automatic test_overrun();
        bus.out_ready = 1'b0;
        fill(8'h30, 8'h31, 8'h32, 8'h33);
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'hFF;
        cyc();
        bus.wr_en = 1'b0;
        n_cmp++;
        if (o_overrun !== 1'b1 || o_count !== 3'd4 || bus.out_data !== 8'h30) begin
            n_bad++;
            $display("FAIL overrun_set: ovr %b count %0d data %h expected 1 4 30",
                     o_overrun, o_count, bus.out_data);
        end
        drain_q("overrun_drain");
        fill(8'h40, 8'h41, 8'h42, 8'h43);
        drain_q("overrun_next");
        n_cmp++;
        if (o_overrun !== 1'b1) begin
            n_bad++;
            $display("FAIL overrun_sticky: ovr %b expected 1", o_overrun);
        end
        do_reset();
        n_cmp++;
        if (o_overrun !== 1'b0) begin
            n_bad++;
            $display("FAIL overrun_clear: ovr %b expected 0", o_overrun);
        end
    endtask

    task automatic test_gap();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = 8'h05 + 8'(i);
            exp_q.push_back(8'h05 + 8'(i));
            cyc();
        end
        bus.wr_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (bus.out_valid !== 1'b0 || o_count !== 3'd2 || bus.wr_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL gap_idle[%0d]: valid %b count %0d wr_ready %b expected 0 2 1",
                         i, bus.out_valid, o_count, bus.wr_ready);
            end
            cyc();
        end
        for (int i = 0; i < 2; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = 8'h07 + 8'(i);
            exp_q.push_back(8'h07 + 8'(i));
            cyc();
            bus.wr_en = 1'b0;
            n_cmp++;
            if (bus.out_valid !== (i == 1)) begin
                n_bad++;
                $display("FAIL gap_valid[%0d]: valid %b expected %b", i, bus.out_valid, i == 1);
            end
        end
        drain_q("gap");
    endtask

    task automatic test_mid_reset();
        logic [7:0] e;
        bus.out_ready = 1'b1;
        fill(8'h51, 8'h52, 8'h53, 8'h54);
        for (int i = 0; i < 2; i++) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (bus.out_data !== e) begin
                n_bad++;
                $display("FAIL midrst_pre[%0d]: data %h expected %h", i, bus.out_data, e);
            end
            cyc();
        end
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (bus.out_valid !== 1'b0 || o_count !== 3'd0 || o_done !== 1'b0 || bus.wr_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL midrst_state[%0d]: valid %b count %0d done %b wr_ready %b expected 0 0 0 1",
                         i, bus.out_valid, o_count, o_done, bus.wr_ready);
            end
            if (i == 0)
                cyc();
        end
        fill(8'h01, 8'h02, 8'h03, 8'h04);
        drain_q("midrst");
    endtask

`ifdef RESULT_DRAIN_PARITY_EN
    task automatic test_parity();
        bus.out_ready = 1'b0;
        fill(8'h03, 8'h07, 8'h0F, 8'h01);
        n_cmp++;
        if (o_out_parity !== 1'b0 || o_parity_err !== 1'b0) begin
            n_bad++;
            $display("FAIL parity_e0: par %b err %b expected 0 0", o_out_parity, o_parity_err);
        end
        bus.out_ready = 1'b1;
        cyc();
        void'(exp_q.pop_front());
        bus.out_ready = 1'b0;
        n_cmp++;
        if (o_out_parity !== 1'b1 || o_parity_err !== 1'b0) begin
            n_bad++;
            $display("FAIL parity_e1: par %b err %b expected 1 0", o_out_parity, o_parity_err);
        end
        dut.r_par_mem[3] = ~dut.r_par_mem[3];
        drain_q("parity");
        n_cmp++;
        if (o_parity_err !== 1'b1) begin
            n_bad++;
            $display("FAIL parity_err: err %b expected 1", o_parity_err);
        end
        do_reset();
    endtask
`endif

    initial begin
        bus.wr_en     = 1'b0;
        bus.wr_data   = 8'h00;
        bus.out_ready = 1'b0;
        reset         = 1'b1;
        test_reset();
        test_basic();
        test_stall();
        test_overrun();
        test_gap();
        test_mid_reset();
`ifdef RESULT_DRAIN_PARITY_EN
        test_parity();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
